// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the sequential multiply/divide unit.
//   - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
//   - FSM state encoding (IDLE, RUN, DONE)
//   - ITER: number of radix-2 iterations per operation
//   - helpers to decode an op and to take a 32-bit magnitude
package muldiv_pkg;

    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // Two's-complement magnitude; 32'h80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 iteration.
//   is_div  : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i   : 64-bit working register
//             multiply: {partial product high, multiplier / product low}
//             divide  : {partial remainder, dividend / quotient bits}
//   opnd_i  : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_o   : working register after this iteration
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        is_div,
    input  logic [63:0] acc_i,
    input  logic [31:0] opnd_i,
    output logic [63:0] acc_o
);

    logic [32:0] sum;     // high half plus multiplicand, carry kept
    logic [32:0] trial;   // 33-bit partial remainder after shifting in next dividend bit
    logic        ge;
    logic [31:0] rem_sub;

    always_comb begin
        sum     = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
        trial   = {acc_i[63:32], acc_i[31]};
        ge      = (trial >= {1'b0, opnd_i});
        // When ge holds, trial - divisor < divisor, so 32 bits hold it exactly.
        rem_sub = trial[31:0] - opnd_i;

        if (is_div) begin
            acc_o = {(ge ? rem_sub : trial[31:0]), acc_i[30:0], ge};
        end else begin
            acc_o = {sum, acc_i[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU unit for the EX stage.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : issue request (ignored while busy or when flush is high)
//   op          : operation select (see muldiv_pkg)
//   busA, busB  : operands (multiplicand/dividend, multiplier/divisor)
//   flush       : squash any in-flight operation, suppress its write
//   stall       : high while iterating (RUN)
//   busy        : high in RUN and DONE
//   multWr      : one-cycle strobe, high the cycle after mult is updated
//   mult        : {HI,LO}; product, or {remainder, quotient}
// Handshake: start is accepted on a posedge only when busy=0 and flush=0;
// exactly one multWr pulse follows 33 edges later unless flushed or reset.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] busA,
    input  logic [31:0] busB,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        multWr,
    output logic [63:0] mult
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [63:0]        acc_q, acc_d;
    logic [63:0]        mult_q, mult_d;
    logic               mult_wr_q, mult_wr_d;

    logic               is_div;
    logic               is_signed;
    logic [31:0]        step_opnd;
    logic [63:0]        step_acc;
    logic               signs_differ;
    logic [31:0]        quo;
    logic [31:0]        rem;
    logic [63:0]        result;

    assign is_div       = op_is_div(op_q);
    assign is_signed    = op_is_signed(op_q);
    assign step_opnd    = is_div ? mag32(b_q, is_signed) : mag32(a_q, is_signed);
    assign signs_differ = is_signed && (a_q[31] ^ b_q[31]);

    muldiv_step u_step (
        .is_div (is_div),
        .acc_i  (acc_q),
        .opnd_i (step_opnd),
        .acc_o  (step_acc)
    );

    // Sign fix-up of the unsigned magnitude result.
    always_comb begin
        quo = acc_q[31:0];
        rem = acc_q[63:32];
        if (!is_div) begin
            result = signs_differ ? (~acc_q + 64'd1) : acc_q;
        end else if (b_q == 32'd0) begin
            // Divide by zero: all-ones quotient, dividend returned unaltered.
            result = {a_q, 32'hFFFF_FFFF};
        end else begin
            result = {((is_signed && a_q[31]) ? (~rem + 32'd1) : rem),
                      (signs_differ ? (~quo + 32'd1) : quo)};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        mult_d    = mult_q;
        mult_wr_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d    = op;
                    a_d     = busA;
                    b_d     = busB;
                    cnt_d   = '0;
                    // Low half seeds with the multiplier or the dividend.
                    acc_d   = {32'd0, (op_is_div(op) ? mag32(busA, op_is_signed(op))
                                                     : mag32(busB, op_is_signed(op)))};
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!flush) begin
                    mult_d    = result;
                    mult_wr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= 2'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            acc_q     <= 64'd0;
            mult_q    <= 64'd0;
            mult_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            mult_q    <= mult_d;
            mult_wr_q <= mult_wr_d;
        end
    end

    assign stall  = (state_q == RUN);
    assign busy   = (state_q != IDLE);
    assign multWr = mult_wr_q;
    assign mult   = mult_q;

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 clk  input  1  pipeline clock; all state changes on posedge clk.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  issue request from EX stage, sampled on posedge clk.
REQ-004 op  input  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
REQ-005 busA  input  32  operand A (multiplicand / dividend).
REQ-006 busB  input  32  operand B (multiplier / divisor).
REQ-007 flush  input  1  abort in-flight operation (branch/exception squash).
REQ-008 stall  output  1  holds IF/ID/ID-EX pipeline registers while high.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 multWr  output  1  one-cycle HI/LO write strobe to EX/MEM.
REQ-011 mult  output  64  result {HI,LO}; MULT/MULTU: product; DIV/DIVU: {remainder,quotient}.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, DONE.
REQ-013 IDLE: start=1 SHALL latch op, busA, busB, load iteration counter with 0, go to RUN; start=0 SHALL remain in IDLE.
REQ-014 RUN SHALL perform one radix-2 step per cycle (shift-add for multiply, restoring subtract-shift for divide) for exactly 32 cycles, counter 0..31, then go to DONE.
REQ-015 DONE SHALL assert multWr for exactly one cycle, update mult, and return to IDLE next cycle.
REQ-016 Latency: start sampled at edge N SHALL yield multWr high in the cycle after edge N+33, mult valid from edge N+33.
REQ-017 stall SHALL be high in RUN and low in IDLE and DONE; busy SHALL be high in RUN and DONE.
REQ-018 start while busy=1 SHALL be ignored (no relatch, no restart).
REQ-019 Signed ops (MULT, DIV) SHALL operate on magnitudes; product negated if operand signs differ; quotient negated if signs differ; remainder takes sign of dividend.
REQ-020 Unsigned ops SHALL treat operands as 32-bit unsigned; internal accumulators SHALL be 64 bits (multiply) and 33 bits (divide partial remainder).
REQ-021 Divide by zero SHALL still run 32 cycles and yield LO=32'hFFFFFFFF, HI=busA (unsigned) / HI=busA (signed, unaltered).
REQ-022 DIV 32'h80000000 / 32'hFFFFFFFF SHALL yield LO=32'h80000000, HI=0.
REQ-023 flush=1 in RUN SHALL return FSM to IDLE next edge, deassert stall, suppress multWr, leave mult unchanged.
REQ-024 flush=1 in DONE SHALL suppress multWr and leave mult unchanged; flush in IDLE SHALL also block a same-cycle start.
REQ-025 mult SHALL hold its last value between completions.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, counter=0, stall=0, busy=0, multWr=0, mult=64'd0, latched operands=0.
REQ-027 Reset asserted mid-RUN SHALL discard the operation; no multWr after reset release.
REQ-028 First start SHALL be accepted at the first posedge clk with rst_n=1.

Structure
REQ-029 Package muldiv_pkg SHALL hold op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state encoding, and ITER=32.
REQ-030 One sub-module muldiv_step SHALL implement a single combinational iteration (multiply add-shift or divide subtract-shift, selected by is_div); muldiv_seq owns FSM, counter, sign fix-up, registers.

Verification
REQ-031 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> multWr at N+33, mult=64'hFFFFFFFE_00000001, stall high 32 cycles.
REQ-032 MULT -3 x 7 -> mult=64'hFFFFFFFF_FFFFFFEB; DIV -7 / 2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
REQ-033 DIVU 100 / 0 -> LO=32'hFFFFFFFF, HI=32'd100; DIV 32'h80000000 / -1 -> LO=32'h80000000, HI=0.
REQ-034 flush at RUN cycle 10 -> stall low next cycle, no multWr, mult retains prior value; new start next cycle completes normally.
REQ-035 start re-pulsed with new operands during RUN -> ignored, result matches first operands; rst_n low at RUN cycle 5 -> all outputs 0 at once, no multWr.
